// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multicycle control FSM and the MIPS
// shared-memory datapath. The master side is the controller; the slave side
// is the datapath (IR fields, ALU zero flag, memory handshake).
//
// Handshake: the controller holds mem_read or mem_write high for as long as
// an access is outstanding; the access completes in the cycle where
// mem_ready is also high, and the controller moves on at the next edge.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    // Datapath -> controller
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;

    // Controller -> datapath
    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal, state, retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal, state, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM. Sequences one instruction over 3-5 states
// and drives every datapath mux select. Moore outputs are registered from
// the next-state value so they are glitch-free decodes of the state; only
// pc_en and ir_write (which must react to mem_ready/zero in the same cycle)
// are combinational.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    mc_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_JAL      = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t           r_state;
    state_t           w_next;
    logic             w_rfunct_ok;
    logic             w_retire;
    logic             w_branch_taken;

    logic             r_iord;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [1:0]       r_reg_dst;
    logic [1:0]       r_mem_to_reg;
    logic             r_reg_write;
    logic             r_alu_src_a;
    logic [1:0]       r_alu_src_b;
    logic [1:0]       r_alu_op;
    logic [1:0]       r_pc_source;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    // Supported R-type functions: add, sub, and, or, slt.
    assign w_rfunct_ok = (bus.funct == 6'h20) || (bus.funct == 6'h22) ||
                         (bus.funct == 6'h24) || (bus.funct == 6'h25) ||
                         (bus.funct == 6'h2A);

    // beq takes the branch on zero, bne on not-zero.
    assign w_branch_taken = (bus.opcode == OP_BEQ) ? bus.zero :
                            (bus.opcode == OP_BNE) ? ~bus.zero : 1'b0;

    // Next-state selection; every non-trap state is left after a fixed
    // number of cycles except the three memory-wait states.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW))
                    w_next = S_MEM_ADDR;
                else if ((bus.opcode == OP_RTYPE) && w_rfunct_ok)
                    w_next = S_R_EXEC;
                else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE))
                    w_next = S_BRANCH;
                else if (bus.opcode == OP_J)
                    w_next = S_JUMP;
                else if (bus.opcode == OP_JAL)
                    w_next = S_JAL;
                else if ((bus.opcode == OP_ADDI) || (bus.opcode == OP_ANDI) ||
                         (bus.opcode == OP_ORI)  || (bus.opcode == OP_SLTI))
                    w_next = S_I_EXEC;
                else
                    w_next = S_TRAP;
            end
            S_MEM_ADDR: w_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   w_next = S_FETCH;
            S_MEM_WR:   w_next = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   w_next = S_R_WB;
            S_R_WB:     w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_I_EXEC:   w_next = S_I_WB;
            S_I_WB:     w_next = S_FETCH;
            S_JAL:      w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    // An instruction retires on its last cycle; a store's last cycle is the
    // one where memory accepts the write.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB, S_JAL: w_retire = 1'b1;
            S_MEM_WR: w_retire = bus.mem_ready;
            default:  w_retire = 1'b0;
        endcase
    end

    // State register, registered Moore outputs (decoded from the next
    // state) and the retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_FETCH;
            r_iord       <= 1'b0;
            r_mem_read   <= 1'b1;
            r_mem_write  <= 1'b0;
            r_reg_dst    <= 2'd0;
            r_mem_to_reg <= 2'd0;
            r_reg_write  <= 1'b0;
            r_alu_src_a  <= 1'b0;
            r_alu_src_b  <= 2'd1;
            r_alu_op     <= 2'b00;
            r_pc_source  <= 2'd0;
            r_illegal    <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_state      <= w_next;
            r_iord       <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_dst    <= 2'd0;
            r_mem_to_reg <= 2'd0;
            r_reg_write  <= 1'b0;
            r_alu_src_a  <= 1'b0;
            r_alu_src_b  <= 2'd0;
            r_alu_op     <= 2'b00;
            r_pc_source  <= 2'd0;
            r_illegal    <= 1'b0;
            case (w_next)
                S_FETCH: begin
                    r_mem_read  <= 1'b1;
                    r_alu_src_b <= 2'd1;
                end
                S_DECODE: begin
                    r_alu_src_b <= 2'd3;
                end
                S_MEM_ADDR: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= 2'd2;
                end
                S_MEM_RD: begin
                    r_iord     <= 1'b1;
                    r_mem_read <= 1'b1;
                end
                S_MEM_WB: begin
                    r_mem_to_reg <= 2'd1;
                    r_reg_write  <= 1'b1;
                end
                S_MEM_WR: begin
                    r_iord      <= 1'b1;
                    r_mem_write <= 1'b1;
                end
                S_R_EXEC: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_op    <= 2'b10;
                end
                S_R_WB: begin
                    r_reg_dst   <= 2'd1;
                    r_reg_write <= 1'b1;
                end
                S_BRANCH: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_op    <= 2'b01;
                    r_pc_source <= 2'd1;
                end
                S_JUMP: begin
                    r_pc_source <= 2'd2;
                end
                S_I_EXEC: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= 2'd2;
                    r_alu_op    <= 2'b11;
                end
                S_I_WB: begin
                    r_reg_write <= 1'b1;
                end
                S_JAL: begin
                    r_reg_dst    <= 2'd2;
                    r_mem_to_reg <= 2'd2;
                    r_reg_write  <= 1'b1;
                    r_pc_source  <= 2'd2;
                end
                S_TRAP: begin
                    r_illegal <= 1'b1;
                end
                default: begin
                    r_mem_read <= 1'b0;
                end
            endcase
            if (w_retire)
                r_retired <= r_retired + 1'b1;
        end
    end

    // PC load: fetch completion, taken branch, and both jump forms.
    assign bus.pc_en = ((r_state == S_FETCH) && bus.mem_ready) ||
                       ((r_state == S_BRANCH) && w_branch_taken) ||
                       (r_state == S_JUMP) || (r_state == S_JAL);

    // IR loads when the instruction fetch completes.
    assign bus.ir_write   = (r_state == S_FETCH) && bus.mem_ready;

    assign bus.iord       = r_iord;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.reg_dst    = r_reg_dst;
    assign bus.mem_to_reg = r_mem_to_reg;
    assign bus.reg_write  = r_reg_write;
    assign bus.alu_src_a  = r_alu_src_a;
    assign bus.alu_src_b  = r_alu_src_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.pc_source  = r_pc_source;
    assign bus.illegal    = r_illegal;
    assign bus.state      = r_state;
    assign bus.retired    = r_retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl. Each instruction is expanded from its class into the
// expected per-cycle trace of states; the outputs expected in each cycle
// come from the state table, and retired is a running instruction count.
module tb_mc_ctrl;

    localparam int CNT_W = 32;

    logic clk;
    logic reset_n;
    int   n_asserts;
    int   n_fail;
    logic [CNT_W-1:0] exp_ret;

    mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction classes
    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BR = 3, C_J = 4,
                   C_JAL = 5, C_I = 6, C_TRAP = 7;

    function automatic int instr_class(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23: return C_LW;
            6'h2B: return C_SW;
            6'h00: return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                           fn == 6'h25 || fn == 6'h2A) ? C_R : C_TRAP;
            6'h04, 6'h05: return C_BR;
            6'h02: return C_J;
            6'h03: return C_JAL;
            6'h08, 6'h0C, 6'h0D, 6'h0A: return C_I;
            default: return C_TRAP;
        endcase
    endfunction

    // Expected outputs packed as
    // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
    //  alu_src_a,alu_src_b,alu_op,pc_source,illegal}
    function automatic logic [17:0] exp_outs(input int st, input logic [5:0] op,
                                             input logic z, input logic mr);
        logic pce, iord, mrd, mwr, irw, rw, asa, ill;
        logic [1:0] rd, m2r, asb, aop, ps;
        pce = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; asa = 0; ill = 0;
        rd = 0; m2r = 0; asb = 0; aop = 0; ps = 0;
        case (st)
            0:  begin mrd = 1; asb = 1; irw = mr; pce = mr; end
            1:  begin asb = 3; end
            2:  begin asa = 1; asb = 2; end
            3:  begin iord = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mwr = 1; end
            6:  begin asa = 1; aop = 2; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 1; ps = 1; pce = (op == 6'h04) ? z : ~z; end
            9:  begin ps = 2; pce = 1; end
            10: begin asa = 1; asb = 2; aop = 3; end
            11: begin rw = 1; end
            12: begin rd = 2; m2r = 2; rw = 1; ps = 2; pce = 1; end
            13: begin ill = 1; end
            default: ;
        endcase
        return {pce, iord, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, ps, ill};
    endfunction

    function automatic logic [17:0] dut_outs();
        return {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, then check state,
    // all outputs and the retired count.
    task automatic check_cycle(input int st, input logic mr, input logic z);
        @(negedge clk);
        bus.mem_ready = mr;
        bus.zero      = z;
        #1;
        chk("state",   32'(bus.state), 32'(st));
        chk("outs",    32'(dut_outs()), 32'(exp_outs(st, bus.opcode, z, mr)));
        chk("retired", bus.retired, exp_ret);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset_n       = 1'b0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        exp_ret = '0;
        chk("rst_state",   32'(bus.state), 32'd0);
        chk("rst_retired", bus.retired, 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        reset_n = 1'b1;
    endtask

    // Run one instruction. fw/mw are the numbers of not-ready cycles in the
    // fetch and in the data access; z is the zero flag seen by a branch.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic z);
        int   q_st[$];
        logic q_mr[$];
        int   cls;
        cls = instr_class(op, fn);
        bus.opcode = op;
        bus.funct  = fn;
        for (int i = 0; i < fw; i++) begin q_st.push_back(0); q_mr.push_back(1'b0); end
        q_st.push_back(0); q_mr.push_back(1'b1);
        q_st.push_back(1); q_mr.push_back(1'($urandom_range(0, 1)));
        case (cls)
            C_LW: begin
                q_st.push_back(2); q_mr.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) begin q_st.push_back(3); q_mr.push_back(1'b0); end
                q_st.push_back(3); q_mr.push_back(1'b1);
                q_st.push_back(4); q_mr.push_back(1'($urandom_range(0, 1)));
            end
            C_SW: begin
                q_st.push_back(2); q_mr.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) begin q_st.push_back(5); q_mr.push_back(1'b0); end
                q_st.push_back(5); q_mr.push_back(1'b1);
            end
            C_R:   begin q_st.push_back(6); q_st.push_back(7);
                         q_mr.push_back(1'($urandom_range(0, 1))); q_mr.push_back(1'($urandom_range(0, 1))); end
            C_BR:  begin q_st.push_back(8);  q_mr.push_back(1'($urandom_range(0, 1))); end
            C_J:   begin q_st.push_back(9);  q_mr.push_back(1'($urandom_range(0, 1))); end
            C_JAL: begin q_st.push_back(12); q_mr.push_back(1'($urandom_range(0, 1))); end
            C_I:   begin q_st.push_back(10); q_st.push_back(11);
                         q_mr.push_back(1'($urandom_range(0, 1))); q_mr.push_back(1'($urandom_range(0, 1))); end
            default: begin
                for (int i = 0; i < 20; i++) begin
                    q_st.push_back(13); q_mr.push_back(1'($urandom_range(0, 1)));
                end
            end
        endcase
        for (int i = 0; i < q_st.size(); i++)
            check_cycle(q_st[i], q_mr[i], (q_st[i] == 8) ? z : 1'($urandom_range(0, 1)));
        if (cls == C_TRAP)
            reset_dut();
        else
            exp_ret = exp_ret + 1'b1;
    endtask

    // Directed steps followed by randomized instructions.
    initial begin
        logic [5:0] legal_ops [11];
        logic [5:0] rfuncts [5];
        logic [5:0] op;
        logic [5:0] fn;
        n_asserts = 0;
        n_fail    = 0;
        exp_ret   = '0;
        reset_n   = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02, 6'h03,
                      6'h08, 6'h0C, 6'h0D, 6'h0A};
        rfuncts   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        repeat (2) @(posedge clk);
        reset_dut();

        run_instr(6'h00, 6'h20, 0, 0, 1'b0);   // add
        run_instr(6'h23, 6'h00, 3, 2, 1'b0);   // lw with wait states
        run_instr(6'h04, 6'h00, 0, 0, 1'b1);   // beq taken
        run_instr(6'h04, 6'h00, 0, 0, 1'b0);   // beq not taken
        run_instr(6'h05, 6'h00, 0, 0, 1'b1);   // bne not taken
        run_instr(6'h05, 6'h00, 0, 0, 1'b0);   // bne taken
        run_instr(6'h03, 6'h00, 1, 0, 1'b0);   // jal
        run_instr(6'h2B, 6'h00, 0, 3, 1'b0);   // sw
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0);   // trap, then reset

        // Reset while a store waits on memory.
        bus.opcode = 6'h2B;
        check_cycle(0, 1'b1, 1'b0);
        check_cycle(1, 1'b0, 1'b0);
        check_cycle(2, 1'b0, 1'b0);
        check_cycle(5, 1'b0, 1'b0);
        check_cycle(5, 1'b0, 1'b0);
        reset_dut();

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                op = 6'($urandom_range(0, 63));
                fn = 6'($urandom_range(0, 63));
            end else begin
                op = legal_ops[$urandom_range(0, 10)];
                fn = rfuncts[$urandom_range(0, 4)];
            end
            run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        end
        check_cycle(0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
